// File: rtl/adder_seq_ctrl.sv
// Wide unsigned adder that time-multiplexes one external 4-bit slice, LSB nibble first.
// Optional subtract mode (A - B, two's complement) enabled by ADDER_SEQ_CTRL_SUB_EN.
module adder_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 i_w_clk,
    input  logic                 i_w_reset,
    input  logic                 i_w_start,
    input  logic [4*NIBBLES-1:0] i_w_a,
    input  logic [4*NIBBLES-1:0] i_w_b,
`ifdef ADDER_SEQ_CTRL_SUB_EN
    input  logic                 i_w_sub,
`endif
    output logic                 o_w_busy,
    output logic                 o_w_done,
    output logic [4*NIBBLES:0]   o_w_sum,
    output logic [3:0]           o_w_add_a,
    output logic [3:0]           o_w_add_b,
    input  logic [4:0]           i_w_add_s
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_res;
    logic [W:0]    r_sum;
    logic          r_carry;
    logic          r_sub;
    logic [IW-1:0] r_idx;

    logic          w_sub_in;
    logic          w_run;
    logic          w_last;
    logic [4:0]    w_t;

`ifdef ADDER_SEQ_CTRL_SUB_EN
    assign w_sub_in = i_w_sub;
`else
    assign w_sub_in = 1'b0;
`endif

    // Operands shift right each RUN cycle, so the current nibble is always at [3:0].
    assign w_run     = (r_state == S_RUN);
    assign w_last    = (r_idx == IW'(NIBBLES - 1));
    assign w_t       = i_w_add_s + {4'd0, r_carry};
    assign o_w_add_a = w_run ? r_a[3:0] : 4'd0;
    assign o_w_add_b = w_run ? (r_b[3:0] ^ {4{r_sub}}) : 4'd0;

    assign o_w_busy  = (r_state != S_IDLE);
    assign o_w_done  = (r_state == S_DONE);
    assign o_w_sum   = r_sum;

    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_w_start) begin
                        r_a     <= i_w_a;
                        r_b     <= i_w_b;
                        r_sub   <= w_sub_in;
                        r_carry <= w_sub_in;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    // Result nibbles enter at the top and settle LSB-first at the bottom.
                    r_res   <= {w_t[3:0], r_res[W-1:4]};
                    r_carry <= w_t[4];
                    r_idx   <= r_idx + IW'(1);
                    if (w_last) begin
                        r_sum   <= {w_t, r_res[W-1:4]};
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Sequencer that performs a wide (4*NIBBLES-bit) addition by time-multiplexing one external 4-bit adder slice (adder_4bits: 4-bit a, 4-bit b, 5-bit sum, no carry-in), one nibble per cycle, LSB first.
- Owns operand latching, nibble selection, carry propagation and result assembly.
- Sits between a start/done requester and the shared adder slice.

Parameters:
- NIBBLES, 4, operand width in nibbles (operand width W = 4*NIBBLES); legal range 2..16.

Ports:
- i_w_clk  input  1  clock; all state updates on rising edge
- i_w_reset  input  1  synchronous, active-high reset
- i_w_start  input  1  request; sampled only in IDLE
- i_w_a  input  W  operand A; sampled on accepted start
- i_w_b  input  W  operand B; sampled on accepted start
- o_w_busy  output  1  high in RUN and DONE
- o_w_done  output  1  one-cycle pulse; result valid
- o_w_sum  output  W+1  result; bit W = final carry
- o_w_add_a  output  4  to adder slice i_w_a
- o_w_add_b  output  4  to adder slice i_w_b
- i_w_add_s  input  5  from adder slice o_w_s (combinational return, same cycle)

Behaviour:
- Reset (i_w_reset=1 at edge): state=IDLE; o_w_busy=0, o_w_done=0, o_w_sum=0, carry=0, nibble index=0; o_w_add_a=o_w_add_b=0. Reset mid-operation aborts; partial result discarded and o_w_sum cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - i_w_start=1 -> latch i_w_a, i_w_b; carry=0; idx=0; -> RUN.
  - o_w_sum holds the last result.
  - o_w_add_a/b driven 0.
- RUN:
  - Drive o_w_add_a = A[4*idx+3:4*idx], o_w_add_b = B[4*idx+3:4*idx] (combinational from latched operands and idx).
  - Each edge: t = i_w_add_s + carry (5-bit; max 15+15+1=31, no overflow); result nibble idx = t[3:0]; carry = t[4]; idx = idx+1.
  - When idx == NIBBLES-1, the same edge writes sum bit W = t[4] and moves to DONE.
  - o_w_sum is updated only at the DONE transition (shadow register); it never exposes partial values.
- DONE: o_w_done=1 for exactly one cycle, o_w_busy=1; -> IDLE unconditionally.
- Latency:
  - Start sampled at edge k -> RUN for NIBBLES cycles -> o_w_done high during cycle k+NIBBLES+1.
  - Next start accepted at the following edge.
  - Throughput: one op per NIBBLES+2 cycles.
- i_w_start while busy: ignored, not queued. Operands may change freely after acceptance.
- i_w_start held high continuously: back-to-back operations, each re-sampling operands in IDLE.
- Arithmetic: unsigned; o_w_sum = A + B exactly, modulo nothing (W+1 bits).

Optional Feature:
- Macro: ADDER_SEQ_CTRL_SUB_EN
- Defined:
  - Adds input port i_w_sub (1 bit), sampled with operands on an accepted start.
  - When i_w_sub=1: o_w_add_b = ~B nibble, initial carry = 1; result = A - B in two's complement over W bits; o_w_sum[W] = 1 means no borrow (A >= B).
  - When i_w_sub=0: behaviour identical to the add-only build.
- Undefined: port absent; addition only; initial carry always 0.

Test Plan:
- All tests: NIBBLES=4, slice = adder_4bits instance.
- Reset, then idle 5 cycles -> o_w_sum=0, o_w_busy=0, o_w_done never pulses, o_w_add_a/b=0.
- A=16'h1234, B=16'h4321, start 1 cycle -> o_w_done pulses exactly 5 cycles after start edge; o_w_sum=17'h05555; o_w_add_a sequence 4,3,2,1 during RUN.
- Full ripple: A=16'hFFFF, B=16'h0001 -> o_w_sum=17'h10000. Then A=B=16'hFFFF -> 17'h1FFFE.
- Start re-pulsed and operands changed during RUN -> ignored; result reflects originally latched operands; only one o_w_done. Start held high for 3 ops -> three done pulses spaced 6 cycles apart.
- Reset asserted in cycle 2 of RUN -> next cycle IDLE, o_w_sum=0, no o_w_done; new op then completes correctly.
- ADDER_SEQ_CTRL_SUB_EN defined, i_w_sub=1:
  - A=16'h0005, B=16'h0003 -> o_w_sum=17'h10002.
  - A=16'h0003, B=16'h0005 -> o_w_sum=17'h0FFFE.
